// File: rtl/aexm_ifetch.sv
// aexm_ifetch: instruction fetch unit with prefetch FIFO feeding the
// instruction buffer; one outstanding I-cache request at a time.
//
// Ports:
//   gclk, grst         clock, synchronous active-high reset
//   gena               pipeline advance (head instruction consumed)
//   rBRA, rBTGT        taken branch (qualified by gena) and byte target
//   ic_stb, ic_adr     I-cache request strobe and word address
//   ic_ack, ic_dat     I-cache completion and returned word
//   aexm_icache_datai  head instruction (NOP when empty)
//   rIPC               byte address of head instruction
//   rFSTALL            fetch starved (FIFO empty)
//
// Build option: define AEXM_IFETCH_PREFETCH_EN for a 4-deep prefetch
// FIFO; otherwise a single holding register is used.

module aexm_ifetch (
    input  logic        gclk,
    input  logic        grst,
    input  logic        gena,
    input  logic        rBRA,
    input  logic [31:0] rBTGT,
    output logic        ic_stb,
    output logic [29:0] ic_adr,
    input  logic        ic_ack,
    input  logic [31:0] ic_dat,
    output logic [31:0] aexm_icache_datai,
    output logic [31:0] rIPC,
    output logic        rFSTALL
);

`ifdef AEXM_IFETCH_PREFETCH_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif
    localparam int CW = $clog2(D) + 1;
    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] DCNT = CW'(D);
    localparam logic [31:0] NOP = 32'h80000000;

    logic [31:0]   fdat [D];
    logic [29:0]   fadr [D];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [29:0]   rFPC;
    logic [29:0]   req_adr;
    logic          pend;
    logic          discard;

    logic empty;
    logic issue;
    logic ack_v;
    logic flush;
    logic take;
    logic pop;
    logic unused_btgt;

    assign unused_btgt = ^rBTGT[1:0];

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        if (D == 1) return '0;
        return p + AW'(1);
    endfunction

    assign empty = (count == '0);

    // A new request goes out combinationally so the first strobe
    // appears in the very first cycle after reset release.
    assign issue  = !grst && !pend && (count < DCNT);
    assign ic_stb = issue || (pend && !grst);

    // Held address keeps ic_adr stable across a redirect of rFPC.
    assign ic_adr = pend ? req_adr : rFPC;

    assign ack_v = ic_stb && ic_ack;
    assign flush = rBRA && gena;
    assign take  = ack_v && !discard && !flush;
    assign pop   = gena && !empty && !flush;

    always_ff @(posedge gclk) begin
        if (grst) begin
            rFPC    <= '0;
            req_adr <= '0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pend    <= 1'b0;
            discard <= 1'b0;
        end else begin
            pend <= ic_stb && !ic_ack;
            if (issue) req_adr <= rFPC;
            // An ack always retires the in-flight request; a flush
            // while it is still in flight poisons its data.
            if (ack_v) discard <= 1'b0;
            else if (flush && ic_stb) discard <= 1'b1;
            if (flush) begin
                rFPC   <= rBTGT[31:2];
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (take) begin
                    rFPC   <= rFPC + 30'd1;
                    wr_ptr <= nxt(wr_ptr);
                end
                if (pop) rd_ptr <= nxt(rd_ptr);
                count <= count + CW'(take) - CW'(pop);
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (take) begin
            fdat[wr_ptr] <= ic_dat;
            fadr[wr_ptr] <= ic_adr;
        end
    end

    always_comb begin
        rFSTALL           = grst || empty;
        aexm_icache_datai = NOP;
        rIPC              = {rFPC, 2'b00};
        if (grst) begin
            rIPC = '0;
        end else if (!empty) begin
            aexm_icache_datai = fdat[rd_ptr];
            rIPC              = {fadr[rd_ptr], 2'b00};
        end
    end

endmodule

// File: tb/tb_aexm_ifetch.sv
// Testbench for aexm_ifetch: randomized cache latency, branches and
// resets, checked by an instruction-stream scoreboard.

module tb_aexm_ifetch;

`ifdef AEXM_IFETCH_PREFETCH_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif
    localparam logic [31:0] NOP = 32'h80000000;

    logic        gclk;
    logic        grst;
    logic        gena;
    logic        rBRA;
    logic [31:0] rBTGT;
    logic        ic_stb;
    logic [29:0] ic_adr;
    logic        ic_ack;
    logic [31:0] ic_dat;
    logic [31:0] aexm_icache_datai;
    logic [31:0] rIPC;
    logic        rFSTALL;

    aexm_ifetch dut (
        .gclk(gclk),
        .grst(grst),
        .gena(gena),
        .rBRA(rBRA),
        .rBTGT(rBTGT),
        .ic_stb(ic_stb),
        .ic_adr(ic_adr),
        .ic_ack(ic_ack),
        .ic_dat(ic_dat),
        .aexm_icache_datai(aexm_icache_datai),
        .rIPC(rIPC),
        .rFSTALL(rFSTALL)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    typedef struct packed {
        logic [31:0] ipc;
        logic [31:0] dat;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    exp_t        sbq[$];
    logic [29:0] exp_pc;
    logic [29:0] iss_q[$];
    int          issued;
    bit          busy;
    int          lat;
    logic [29:0] req_a;
    bit          prev_rst = 1'b1;
    bit          fixed_lat;

    function automatic logic [31:0] mem(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h3c5a9e01;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, req);
        end
    endtask

    // Memory-side responder: ack after a chosen latency, data = mem(adr).
    task automatic step_cache();
        int r;
        if (ic_stb) begin
            if (!busy) begin
                busy = 1'b1;
                req_a = ic_adr;
                issued++;
                iss_q.push_back(ic_adr);
                r = $urandom_range(0, 9);
                if (fixed_lat) lat = 1;
                else if (r < 3) lat = 0;
                else if (r < 7) lat = 1;
                else lat = $urandom_range(2, 6);
            end else begin
                chk("adr_stable", {2'b00, ic_adr}, {2'b00, req_a});
            end
            if (lat == 0) begin
                ic_ack = 1'b1;
                ic_dat = mem(ic_adr);
                busy = 1'b0;
            end else begin
                ic_ack = 1'b0;
                ic_dat = $urandom;
                lat--;
            end
        end else begin
            if (busy) chk("stb_held", {31'b0, ic_stb}, 32'd1);
            busy = 1'b0;
            ic_ack = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_tgt();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'hFFFFFFFC;
        if (r == 1) return 32'hFFFFFFF4;
        if (r == 2) return 32'h00000200;
        return $urandom;
    endfunction

    // Monitor: pops consumed instructions and compares them.
    always @(negedge gclk) begin
        exp_t e;
        if (grst) begin
            chk("rst_stb", {31'b0, ic_stb}, 32'd0);
            chk("rst_stall", {31'b0, rFSTALL}, 32'd1);
            chk("rst_dat", aexm_icache_datai, NOP);
            chk("rst_ipc", rIPC, 32'd0);
        end else begin
            if (prev_rst) begin
                chk("rel_stb", {31'b0, ic_stb}, 32'd1);
                chk("rel_adr", {2'b00, ic_adr}, 32'd0);
            end
            if (gena && !rFSTALL) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underrun: got pop want none");
                end else begin
                    e = sbq.pop_front();
                    chk("ipc", rIPC, e.ipc);
                    chk("dat", aexm_icache_datai, e.dat);
                    pops++;
                end
            end
            if (rFSTALL) begin
                chk("empty_nop", aexm_icache_datai, NOP);
                if (!(gena && rBRA))
                    chk("empty_ipc", rIPC, {exp_pc, 2'b00});
            end
        end
        prev_rst = grst;
    end

    initial begin
        exp_t e;
        int rate;
        grst = 1'b1;
        gena = 1'b0;
        rBRA = 1'b0;
        rBTGT = '0;
        ic_ack = 1'b0;
        ic_dat = '0;
        exp_pc = '0;
        busy = 1'b0;
        lat = 0;
        issued = 0;
        fixed_lat = 1'b1;
        repeat (3) @(posedge gclk);
        #1;
        grst = 1'b0;

        // Fill with gena held low and single-cycle ack latency.
        for (int c = 0; c < 14; c++) begin
            step_cache();
            @(posedge gclk);
            #1;
        end
        chk("fill_count", issued, D);
        for (int i = 0; i < D && i < iss_q.size(); i++)
            chk("fill_adr", {2'b00, iss_q[i]}, i);
        chk("fill_stb", {31'b0, ic_stb}, 32'd0);
        chk("fill_head_ipc", rIPC, 32'd0);
        chk("fill_head_dat", aexm_icache_datai, mem(30'd0));

        fixed_lat = 1'b0;
        rate = 3;
        for (int c = 0; c < 5000; c++) begin
            if (c % 64 == 0) rate = $urandom_range(0, 4);
            if (grst) begin
                grst = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                grst = 1'b1;
                gena = 1'b0;
                rBRA = 1'b0;
                ic_ack = 1'($urandom_range(0, 1));
                ic_dat = $urandom;
                busy = 1'b0;
                sbq.delete();
                exp_pc = '0;
                @(posedge gclk);
                #1;
                continue;
            end
            step_cache();
            gena = ($urandom_range(0, 3) < rate);
            rBRA = ($urandom_range(0, 15) == 0);
            rBTGT = pick_tgt();
            if (gena && !rFSTALL) begin
                e.ipc = {exp_pc, 2'b00};
                e.dat = mem(exp_pc);
                sbq.push_back(e);
                exp_pc = exp_pc + 30'd1;
            end
            if (gena && rBRA) exp_pc = rBTGT[31:2];
            @(posedge gclk);
            #1;
        end
        gena = 1'b0;
        rBRA = 1'b0;
        grst = 1'b0;
        @(posedge gclk);
        #1;
        chk("liveness", {31'b0, pops >= 200}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
